vc_buffer_bank: RTL

- Multi-virtual-channel input buffer for one router input port.
- Holds N_VC independent flit FIFOs, demultiplexed by incoming VC id.
- Enforces per-VC wormhole packet locking on the write side.
- Merges all VCs onto one output towards router ctrl via a packet-granular round-robin arbiter, so flits of one packet are never interleaved with another VC's flits.

---
 rtl/ravenoc_pkg.sv | 40 ++++
 rtl/fifo.sv | 53 +++++
 rtl/vc_rr_arbiter.sv | 99 +++++++++
 rtl/vc_buffer_bank.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/ravenoc_pkg.sv
// Shared NoC flit definitions: flit layout, flit types, sizing constants and arbiter states.
// Decode helpers keep the field extraction in one place for every consumer of raw flit words.
package ravenoc_pkg;

  localparam int FLIT_WIDTH = 34;
  localparam int FLIT_BUFF  = 4;
  localparam int PKT_SIZE_W = 8;
  localparam logic [PKT_SIZE_W-1:0] MIN_SIZE_FLIT = 8'd1;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'b00,
    BODY_FLIT = 2'b01,
    TAIL_FLIT = 2'b10
  } flit_type_t;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // pkt_size counts every flit of the packet, head included
  typedef struct packed {
    flit_type_t                           type_f;
    logic [PKT_SIZE_W-1:0]                pkt_size;
    logic [FLIT_WIDTH-PKT_SIZE_W-3:0]     payload;
  } s_flit_head_data_t;

  function automatic flit_type_t flit_type(input logic [FLIT_WIDTH-1:0] f);
    s_flit_head_data_t h;
    h = s_flit_head_data_t'(f);
    return h.type_f;
  endfunction

  function automatic logic flit_is_multi_head(input logic [FLIT_WIDTH-1:0] f);
    s_flit_head_data_t h;
    h = s_flit_head_data_t'(f);
    return (h.type_f == HEAD_FLIT) && (h.pkt_size != MIN_SIZE_FLIT);
  endfunction

endpackage

// File: rtl/fifo.sv
// Generic synchronous FIFO, SLOTS a power of two; head word visible one cycle after its write.
// Writes while full and reads while empty are ignored; no write-through when full.
module fifo #(
  parameter int SLOTS = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(SLOTS);

  logic [WIDTH-1:0] mem_q [SLOTS];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign do_wr   = write_i && !full_o;
  assign do_rd   = read_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
  end

endmodule

// File: rtl/vc_rr_arbiter.sv
// Packet-granular round-robin grant over VC requests; grant is combinational from registered state.
// A presented but unpopped grant is held, and a multi-flit packet keeps the grant until its tail pops.
module vc_rr_arbiter
  import ravenoc_pkg::*;
#(
  parameter  int N_VC   = 2,
  localparam int VC_IDW = $clog2(N_VC > 1 ? N_VC : 2)
) (
  input  logic              clk,
  input  logic              arst,
  input  logic [N_VC-1:0]   req_i,
  input  logic              pop_i,
  input  logic              pop_multi_head_i,
  input  logic              pop_tail_i,
  output logic              gnt_vld_o,
  output logic [VC_IDW-1:0] gnt_o
);

  localparam logic [0:0] S_IDLE   = ARB_IDLE;
  localparam logic [0:0] S_LOCKED = ARB_LOCKED;

  logic [0:0]        state_q, state_d;
  logic [VC_IDW-1:0] ptr_q, ptr_d;
  logic [VC_IDW-1:0] lock_vc_q, lock_vc_d;
  logic              hold_q, hold_d;
  logic [VC_IDW-1:0] hold_vc_q, hold_vc_d;
  logic [VC_IDW-1:0] pick;
  logic              found;
  int                idx;

  function automatic logic [VC_IDW-1:0] next_vc(input logic [VC_IDW-1:0] v);
    return (int'(v) == N_VC - 1) ? '0 : v + VC_IDW'(1);
  endfunction

  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N_VC; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_VC) idx = idx - N_VC;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        pick  = VC_IDW'(idx);
      end
    end
  end

  // A new request ahead of a waiting grant must not steal the output
  always_comb begin
    gnt_o     = pick;
    gnt_vld_o = found;
    if (state_q == S_LOCKED) begin
      gnt_o     = lock_vc_q;
      gnt_vld_o = req_i[lock_vc_q];
    end else if (hold_q) begin
      gnt_o     = hold_vc_q;
      gnt_vld_o = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    lock_vc_d = lock_vc_q;
    hold_d    = (state_q == S_IDLE) && gnt_vld_o && !pop_i;
    hold_vc_d = gnt_o;
    if (gnt_vld_o && pop_i) begin
      if (state_q == S_IDLE) begin
        if (pop_multi_head_i) begin
          state_d   = S_LOCKED;
          lock_vc_d = gnt_o;
        end else begin
          ptr_d = next_vc(gnt_o);
        end
      end else if (pop_tail_i) begin
        state_d = S_IDLE;
        ptr_d   = next_vc(lock_vc_q);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      lock_vc_q <= '0;
      hold_q    <= 1'b0;
      hold_vc_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      lock_vc_q <= lock_vc_d;
      hold_q    <= hold_d;
      hold_vc_q <= hold_vc_d;
    end
  end

endmodule

// File: rtl/vc_buffer_bank.sv
// Router input-port buffer: per-VC flit FIFOs with wormhole write locks, merged by a packet-granular RR arbiter.
// Flits reach fdata_o one cycle after write at the earliest; VC_BUFFER_OCCUPANCY_EN adds per-VC counts on vc_occ_o.
module vc_buffer_bank
  import ravenoc_pkg::*;
#(
  parameter  int N_VC       = 2,
  parameter  int BUFF_DEPTH = FLIT_BUFF,
  parameter  int FLIT_W     = FLIT_WIDTH,
  localparam int VC_IDW     = $clog2(N_VC > 1 ? N_VC : 2),
  localparam int OCC_W      = $clog2(BUFF_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic [FLIT_W-1:0]      fdata_i,
  input  logic [VC_IDW-1:0]      vc_id_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [FLIT_W-1:0]      fdata_o,
  output logic [VC_IDW-1:0]      vc_id_o,
  output logic                   valid_o,
  input  logic                   ready_i,
`ifdef VC_BUFFER_OCCUPANCY_EN
  output logic [N_VC*OCC_W-1:0]  vc_occ_o,
`endif
  output logic [N_VC-1:0]        vc_full_o
);

  logic [N_VC-1:0]   full, empty;
  logic [N_VC-1:0]   wlock_q, wlock_d;
  logic [N_VC-1:0]   wr_vec, pop_vec;
  logic [FLIT_W-1:0] vc_dat [N_VC];
  logic [FLIT_W-1:0] head_dat;
  logic              sel_full, sel_wlock;
  logic              wr_en, pop, gnt_vld;
  logic [VC_IDW-1:0] grant;
  flit_type_t        in_type;
  logic              in_multi;
  logic              out_multi, out_tail;

  assign in_type  = flit_type(fdata_i[FLIT_WIDTH-1:0]);
  assign in_multi = flit_is_multi_head(fdata_i[FLIT_WIDTH-1:0]);

  // Out-of-range VC ids fall through to the "full" default and are never accepted
  always_comb begin
    sel_full  = 1'b1;
    sel_wlock = 1'b0;
    for (int v = 0; v < N_VC; v++) begin
      if (vc_id_i == VC_IDW'(v)) begin
        sel_full  = full[v];
        sel_wlock = wlock_q[v];
      end
    end
  end

  assign ready_o = !sel_full && ((in_type != HEAD_FLIT) || !sel_wlock);
  assign wr_en   = valid_i && ready_o;
  assign pop     = gnt_vld && ready_i;

  always_comb begin
    wlock_d = wlock_q;
    wr_vec  = '0;
    pop_vec = '0;
    for (int v = 0; v < N_VC; v++) begin
      wr_vec[v]  = wr_en && (vc_id_i == VC_IDW'(v));
      pop_vec[v] = pop && (grant == VC_IDW'(v));
      if (wr_vec[v]) begin
        if (in_type == HEAD_FLIT && in_multi) wlock_d[v] = 1'b1;
        else if (in_type == TAIL_FLIT)        wlock_d[v] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) wlock_q <= '0;
    else      wlock_q <= wlock_d;
  end

  for (genvar v = 0; v < N_VC; v++) begin : g_vc
    fifo #(
      .SLOTS (BUFF_DEPTH),
      .WIDTH (FLIT_W)
    ) u_fifo (
      .clk     (clk),
      .arst    (arst),
      .write_i (wr_vec[v]),
      .read_i  (pop_vec[v]),
      .data_i  (fdata_i),
      .data_o  (vc_dat[v]),
      .full_o  (full[v]),
      .empty_o (empty[v])
    );
  end

  assign head_dat  = vc_dat[grant];
  assign out_multi = flit_is_multi_head(head_dat[FLIT_WIDTH-1:0]);
  assign out_tail  = (flit_type(head_dat[FLIT_WIDTH-1:0]) == TAIL_FLIT);

  vc_rr_arbiter #(
    .N_VC (N_VC)
  ) u_arb (
    .clk              (clk),
    .arst             (arst),
    .req_i            (~empty),
    .pop_i            (pop),
    .pop_multi_head_i (out_multi),
    .pop_tail_i       (out_tail),
    .gnt_vld_o        (gnt_vld),
    .gnt_o            (grant)
  );

  // Storage is not reset, so the data path is masked while nothing is offered
  assign valid_o   = gnt_vld;
  assign fdata_o   = gnt_vld ? head_dat : '0;
  assign vc_id_o   = grant;
  assign vc_full_o = full;

`ifdef VC_BUFFER_OCCUPANCY_EN
  logic [OCC_W-1:0] occ_q [N_VC];
  logic [OCC_W-1:0] occ_d [N_VC];

  always_comb begin
    for (int v = 0; v < N_VC; v++) begin
      occ_d[v] = occ_q[v];
      if (wr_vec[v] && !pop_vec[v])      occ_d[v] = occ_q[v] + OCC_W'(1);
      else if (!wr_vec[v] && pop_vec[v]) occ_d[v] = occ_q[v] - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      for (int v = 0; v < N_VC; v++) occ_q[v] <= '0;
    end else begin
      for (int v = 0; v < N_VC; v++) occ_q[v] <= occ_d[v];
    end
  end

  for (genvar v = 0; v < N_VC; v++) begin : g_occ
    assign vc_occ_o[v*OCC_W +: OCC_W] = occ_q[v];
  end
`endif

`ifndef NO_ASSERTIONS
  a_no_overflow: assert property (@(posedge clk) disable iff (arst)
    (wr_vec & full) == '0);
  a_no_underflow: assert property (@(posedge clk) disable iff (arst)
    (pop_vec & empty) == '0);
  a_body_needs_lock: assert property (@(posedge clk) disable iff (arst)
    (wr_en && in_type != HEAD_FLIT) |-> sel_wlock);
  a_head_unlocked: assert property (@(posedge clk) disable iff (arst)
    (wr_en && in_type == HEAD_FLIT) |-> !sel_wlock);
  a_out_stable: assert property (@(posedge clk) disable iff (arst)
    (valid_o && !ready_i) |=> (valid_o && $stable(fdata_o) && $stable(vc_id_o)));
`endif

endmodule
